// File: rtl/brick_renderer.sv
// brick_renderer: sweeps the brick health store and plots every brick rectangle
// to the VGA adapter, coloured by health.
// Optional macro BRICK_SKIP_EMPTY_EN: bricks with health 0 are skipped (no plots).
`timescale 1ns/1ps
module brick_renderer #(
   parameter int unsigned COLS    = 16,
   parameter int unsigned ROWS    = 16,
   parameter int unsigned BRICK_W = 10,
   parameter int unsigned BRICK_H = 4,
   parameter int unsigned X_OFF   = 0,
   parameter int unsigned Y_OFF   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] mem_addr,
   input  logic [1:0] mem_q,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] colour,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] COL_LAST = 8'(COLS - 1);
   localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
   localparam logic [7:0] PX_LAST  = 8'(BRICK_W - 1);
   localparam logic [7:0] PY_LAST  = 8'(BRICK_H - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] row_q, row_d, col_q, col_d;
   logic [7:0] px_q, px_d, py_q, py_d;
   logic [1:0] health_q, health_d;
   logic [7:0] mem_addr_q, mem_addr_d;
   logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
   logic [7:0] vga_x_q, vga_x_d;
   logic [6:0] vga_y_q, vga_y_d;
   logic [2:0] colour_q, colour_d;
   logic       adv;

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         px_q       <= '0;
         py_q       <= '0;
         health_q   <= '0;
         mem_addr_q <= '0;
         plot_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         colour_q   <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         px_q       <= px_d;
         py_q       <= py_d;
         health_q   <= health_d;
         mem_addr_q <= mem_addr_d;
         plot_q     <= plot_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         colour_q   <= colour_d;
      end
   end

   // Next state and brick/pixel counter sequencing
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      px_d     = px_q;
      py_d     = py_q;
      health_d = health_q;
      adv      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               row_d   = '0;
               col_d   = '0;
               px_d    = '0;
               py_d    = '0;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            health_d = mem_q;
            px_d     = '0;
            py_d     = '0;
`ifdef BRICK_SKIP_EMPTY_EN
            if (mem_q == 2'd0) adv = 1'b1;
            else               state_d = DRAW;
`else
            state_d = DRAW;
`endif
         end
         DRAW: begin
            if (px_q == PX_LAST) begin
               px_d = '0;
               if (py_q == PY_LAST) adv = 1'b1;
               else                 py_d = py_q + 8'd1;
            end else begin
               px_d = px_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Move on to the next brick in raster order, or finish after the last one
      if (adv) begin
         if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d = DONE;
         end else begin
            state_d = FETCH;
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + 8'd1;
            end else begin
               col_d = col_q + 8'd1;
            end
         end
      end
   end

   // Outputs computed from the next state so they align with it when registered
   always_comb begin
      plot_d     = (state_d == DRAW);
      busy_d     = (state_d == FETCH) || (state_d == WAIT) || (state_d == DRAW);
      done_d     = (state_d == DONE);
      mem_addr_d = 8'(16'(row_d) * 16'(COLS) + 16'(col_d));
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      colour_d   = colour_q;
      if (plot_d) begin
         vga_x_d = 8'(16'(X_OFF) + 16'(col_d) * 16'(BRICK_W) + 16'(px_d));
         vga_y_d = 7'(16'(Y_OFF) + 16'(row_d) * 16'(BRICK_H) + 16'(py_d));
         case (health_d)
            2'd3:    colour_d = 3'b100;
            2'd2:    colour_d = 3'b110;
            2'd1:    colour_d = 3'b010;
            default: colour_d = 3'b000;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign plot     = plot_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign vga_x    = vga_x_q;
   assign vga_y    = vga_y_q;
   assign colour   = colour_q;

endmodule

// File: tb/tb_brick_renderer.sv
// Testbench for brick_renderer: a frame-level model predicts every plot (position,
// colour, cycle) from the store contents; a monitor thread checks each plot.
`timescale 1ns/1ps
module tb_brick_renderer;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] mem_addr;
   logic [1:0] mem_q;
   logic       plot, busy, done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;

   brick_renderer dut (
      .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_q(mem_q),
      .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Health store with a 1-cycle synchronous read
   logic [1:0] mem [256];
   always @(posedge clk) mem_q <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int x; int y; int c; int t; } pix_t;
   pix_t exp_q[$];
   int   exp_done, exp_plots;

   int checks = 0, errors = 0;
   int t0, plots, done_cnt, done_cyc;
   int first_x, first_y, first_c, last_x, last_y, probe_c;
   bit mode_active = 1'b0;
   bit ab;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int cmap(input logic [1:0] h);
      case (h)
         2'd3:    return 4;
         2'd2:    return 6;
         2'd1:    return 2;
         default: return 0;
      endcase
   endfunction

   // Frame model: 16x16 bricks of 10x4 pixels, 2 setup cycles per brick
   task automatic build_model();
      int t;
      bit drawn;
      exp_q.delete();
      t = 0;
      for (int a = 0; a < 256; a++) begin
         t += 2;
         drawn = 1'b1;
`ifdef BRICK_SKIP_EMPTY_EN
         if (mem[a] == 2'd0) drawn = 1'b0;
`endif
         if (drawn)
            for (int py = 0; py < 4; py++)
               for (int px = 0; px < 10; px++) begin
                  pix_t p;
                  t++;
                  p.x = (a % 16) * 10 + px;
                  p.y = 8 + (a / 16) * 4 + py;
                  p.c = cmap(mem[a]);
                  p.t = t;
                  exp_q.push_back(p);
               end
      end
      exp_done  = t + 1;
      exp_plots = exp_q.size();
   endtask

   task automatic fill(input logic [1:0] h);
      for (int a = 0; a < 256; a++) mem[a] = h;
   endtask

   // Checks every plot against the model; outside a sweep any plot/done is wrong
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mode_active) begin
            if (plot) begin
               if (exp_q.size() == 0) begin
                  check("extra_plot", 1, 0);
               end else begin
                  pix_t e;
                  e = exp_q.pop_front();
                  checks++;
                  if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(colour) != e.c ||
                      (cyc - t0) != e.t) begin
                     errors++;
                     $display("FAIL pixel: got x=%0d y=%0d c=%0d cyc=%0d expected x=%0d y=%0d c=%0d cyc=%0d",
                              vga_x, vga_y, colour, cyc - t0, e.x, e.y, e.c, e.t);
                  end
               end
               if (plots == 0) begin
                  first_x = int'(vga_x); first_y = int'(vga_y); first_c = int'(colour);
               end
               last_x = int'(vga_x); last_y = int'(vga_y);
               if (vga_x == 8'd15 && vga_y == 7'd13) probe_c = int'(colour);
               plots++;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc - t0;
               check("busy_at_done", int'(busy), 0);
            end
         end else if (plot || done) begin
            check("idle_activity", int'({plot, done}), 0);
         end
      end
   endtask

   // One sweep; optional extra start pulse or reset at given sweep cycles
   task automatic run_sweep(input int restart_at, input int reset_at, output bit aborted);
      int n;
      aborted  = 1'b0;
      build_model();
      plots    = 0; done_cnt = 0; done_cyc = -1;
      first_x  = -1; first_y = -1; first_c = -1; last_x = -1; last_y = -1; probe_c = -1;
      @(negedge clk);
      t0 = cyc;
      mode_active = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = cyc - t0;
      while (done_cnt == 0 && n < exp_done + 50) begin
         start = (n == restart_at - 1);
         if (n == 100) check("busy_mid", int'(busy), 1);
         if (n == reset_at - 1) begin
            @(posedge clk);
            #2;
            mode_active = 1'b0;
            exp_q.delete();
            reset = 1'b1;
            #1;
            check("rst_plot", int'(plot), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            @(posedge clk);
            #2;
            reset = 1'b0;
            repeat (300) @(negedge clk);
            aborted = 1'b1;
            return;
         end
         @(negedge clk);
         n = cyc - t0;
      end
      start = 1'b0;
      repeat (5) @(negedge clk);
      mode_active = 1'b0;
      check("done_count", done_cnt, 1);
      check("done_cycle", done_cyc, exp_done);
      check("plot_count", plots, exp_plots);
      check("missing_plots", exp_q.size(), 0);
      check("busy_after", int'(busy), 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      fill(2'd0);
      fork monitor(); join_none
      repeat (2) @(negedge clk);
      check("reset_plot", int'(plot), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_addr", int'(mem_addr), 0);
      check("reset_x", int'(vga_x), 0);
      check("reset_y", int'(vga_y), 0);
      check("reset_colour", int'(colour), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // All bricks at full health
      fill(2'd3);
      run_sweep(0, 0, ab);
      check("t1_first_x", first_x, 0);
      check("t1_first_y", first_y, 8);
      check("t1_first_c", first_c, 4);
      check("t1_last_x", last_x, 159);
      check("t1_last_y", last_y, 71);
      check("t1_done_cyc", done_cyc, 10753);
      check("t1_plots", plots, 10240);

      // One yellow brick at address 17
      fill(2'd1);
      mem[17] = 2'd2;
      run_sweep(0, 0, ab);
      check("t2_probe_yellow", probe_c, 6);
      check("t2_first_green", first_c, 2);

      // Extra start mid-sweep is ignored
      run_sweep(500, 0, ab);
      check("t3_done_cyc", done_cyc, 10753);
      check("t3_plots", plots, 10240);

      // Reset mid-sweep, then a clean full sweep
      fill(2'd3);
      run_sweep(0, 2000, ab);
      check("t4_aborted", int'(ab), 1);
      run_sweep(0, 0, ab);
      check("t4_plots", plots, 10240);

      // Each brick differs from its predecessor
      for (int a = 0; a < 256; a++) mem[a] = 2'((a + a / 4) % 4);
      run_sweep(0, 0, ab);

      // Only the last brick alive
      fill(2'd0);
      mem[255] = 2'd1;
      run_sweep(0, 0, ab);
`ifdef BRICK_SKIP_EMPTY_EN
      check("t6_plots", plots, 40);
      check("t6_done_cyc", done_cyc, 553);
      check("t6_first_x", first_x, 150);
      check("t6_first_y", first_y, 68);
`else
      check("t6_plots", plots, 10240);
      check("t6_done_cyc", done_cyc, 10753);
      check("t6_last_x", last_x, 159);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/brick_renderer.md
Name: brick_renderer

Overview:
- Read-side companion to the brick health store.
- On a start pulse, sweeps every brick address in order and reads each 2-bit health value through the store's synchronous read port (1-cycle latency).
- For each brick, emits one plot per pixel of its rectangle to the VGA adapter, coloured by health.
- Sits between the game controller (start/done) and the VGA adapter (plot/x/y/colour).

Parameters:
- COLS, 16, bricks per row.
- ROWS, 16, brick rows. COLS*ROWS must be ≤ 256.
- BRICK_W, 10, brick width in pixels.
- BRICK_H, 4, brick height in pixels.
- X_OFF, 0, screen x of the left edge of column 0.
- Y_OFF, 8, screen y of the top edge of row 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to redraw all bricks; sampled only in IDLE.
- mem_addr  out  8  brick address to the health store, row*COLS+col.
- mem_q  in  2  health read data from the store; valid one cycle after mem_addr is presented.
- plot  out  1  pixel write strobe to the VGA adapter.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- colour  out  3  pixel colour, RGB.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset values: state=IDLE; mem_addr, vga_x, vga_y, colour = 0; plot, busy, done = 0. All outputs are registered.
- Reset mid-sweep: returns to IDLE immediately. plot drops at once. No done pulse is issued.
- FSM states: IDLE, FETCH, WAIT, DRAW, DONE.
  - IDLE: start=1 → FETCH. Brick counters row=0, col=0; mem_addr=0.
  - FETCH, 1 cycle: mem_addr held; the store registers the address at the end of this cycle.
  - WAIT, 1 cycle: mem_q is valid. Health is latched at the end of the cycle; pixel counters px=0, py=0.
  - DRAW, BRICK_W*BRICK_H cycles: one pixel per cycle with plot=1.
    - Pixel order: px increments fastest; when px wraps from BRICK_W-1, py increments.
    - vga_x = X_OFF + col*BRICK_W + px; vga_y = Y_OFF + row*BRICK_H + py, both truncated to port width.
  - After the last pixel (px=BRICK_W-1, py=BRICK_H-1):
    - If row=ROWS-1 and col=COLS-1 → DONE.
    - Otherwise the next brick is selected: col increments, wrapping to 0 with row incrementing. mem_addr updates, then → FETCH.
  - DONE, 1 cycle: done=1, busy=0, then → IDLE.
- Cycles per brick: 2 + BRICK_W*BRICK_H, which is 42 at defaults.
- Total sweep: the first plot occurs 3 cycles after start is sampled. done is asserted in the cycle after the last plot. With defaults, done occurs 256*42+1 = 10753 cycles after start is sampled.
- Colour map, applied to the latched health:
  - 3 → 3'b100 (red)
  - 2 → 3'b110 (yellow)
  - 1 → 3'b010 (green)
  - 0 → 3'b000 (background; erases destroyed bricks)
- Start handling: start while busy is ignored, with no restart and no queuing. start in the DONE cycle is also ignored.
- No writes: the block never writes to the health store. Write arbitration is owned by the game controller, which must not write during busy.

Optional Feature:
- Macro: BRICK_SKIP_EMPTY_EN.
- Defined: a brick with latched health 0 skips DRAW entirely. WAIT goes straight to next-brick selection, so the brick costs 2 cycles and produces no plot. Erasure is then the collision logic's responsibility.
- Undefined: every brick is drawn, and health 0 bricks are drawn in background colour (default behaviour above).

Test Plan:
- All healths=3, pulse start → exactly 10240 plots with colour=3'b100. First plot at (0,8), last plot at (159,71). done pulses once at cycle 10753; busy is low afterwards.
- Store address 17 = health 2, others 1 → plots for x in 10..19, y in 12..15 have colour 3'b110; all other plots are 3'b010.
- Pulse start again at sweep cycle 500 → ignored: plot count and done timing identical to an undisturbed sweep.
- Assert reset at sweep cycle 2000 for 1 cycle → plot, busy, done=0 immediately. No done pulse follows. A new start gives a full, correct sweep.
- Read-latency check: model the store with exactly 1-cycle latency and a different health per brick → each brick's colour matches its own address, never the previous brick's.
- BRICK_SKIP_EMPTY_EN defined, all healths 0 except address 255=1 → exactly 40 plots, all colour 3'b010 at x 150..159, y 68..71. done at cycle 255*2+42+1 = 553.
